// File: rtl/dm_arbiter.sv
// dm_arbiter: single-port data-memory arbiter between the M stage and one
// external bus master, with a bounded-starvation wait counter for the master.
module dm_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_byte,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic        ext_byte,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wd,
    output logic        ext_gnt,
    output logic        ext_done,
    output logic [31:0] ext_rd,
    output logic        dm_we,
    output logic        dm_byte,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    input  logic [31:0] dm_rd
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DONE = 1'b1
    } state_t;

    localparam logic [3:0] LP_STARVE = 4'(STARVE_MAX);
    localparam logic [3:0] LP_SAT    = 4'hF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_wait_nxt;
    logic [31:0] r_ext_rd;
    logic        w_ext_win;
    logic        w_cpu_lost;

    // Grant decision and next state; ext can only win from IDLE, out of reset
    always_comb begin
        w_ext_win   = 1'b0;
        w_state_nxt = r_state;
        if (reset && (r_state == S_IDLE) && ext_req &&
            (!cpu_req || (r_wait_cnt >= LP_STARVE))) begin
            w_ext_win = 1'b1;
        end
        case (r_state)
            S_IDLE:  w_state_nxt = w_ext_win ? S_DONE : S_IDLE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Starvation counter: counts IDLE cycles the pending ext request loses
    always_comb begin
        w_wait_nxt = r_wait_cnt;
        w_cpu_lost = ext_req && (r_state == S_IDLE) && cpu_req && !w_ext_win;
        if (w_ext_win || !ext_req) begin
            w_wait_nxt = 4'd0;
        end else if (w_cpu_lost && (r_wait_cnt != LP_SAT)) begin
            w_wait_nxt = r_wait_cnt + 4'd1;
        end
    end

    // DM port mux; write enable never follows a requester that lacks the port
    always_comb begin
        dm_we   = 1'b0;
        dm_byte = cpu_byte;
        dm_addr = cpu_addr;
        dm_wd   = cpu_wd;
        if (w_ext_win) begin
            dm_we   = ext_we;
            dm_byte = ext_byte;
            dm_addr = ext_addr;
            dm_wd   = ext_wd;
        end else if (reset) begin
            dm_we   = cpu_we & cpu_req;
        end
    end

    // Requester-facing outputs
    always_comb begin
        ext_gnt   = w_ext_win;
        cpu_stall = w_ext_win & cpu_req;
        cpu_rd    = (reset && !w_ext_win) ? dm_rd : 32'd0;
        ext_done  = (r_state == S_DONE);
        ext_rd    = r_ext_rd;
    end

    // State, wait counter and captured external read data
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
            r_ext_rd   <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_ext_win) begin
                r_ext_rd <= dm_rd;
            end
        end
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Single-port data-memory arbiter between the pipeline's M stage and one external bus master (debug/DMA bridge). It owns the DM control inputs (write enable, byte mode, address, write data), grants one requester per cycle, stalls the pipeline when the external master wins, and bounds external-master starvation with a wait counter. It sits between the M-stage datapath and the DM instance; the DM keeps its combinational read and edge-triggered write.

## Interface
- STARVE_MAX, 4: contended cycles an external request may lose to the CPU before it is forced through; legal range 1..15.
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low; sampled on rising edge of clk.
- cpu_req  input  1  M-stage instruction accesses DM (load or store).
- cpu_we  input  1  store enable.
- cpu_byte  input  1  byte-mode access.
- cpu_addr  input  32  byte address (ALU result).
- cpu_wd  input  32  store data (forwarded rt value).
- cpu_rd  output  32  load data to W pipeline register.
- cpu_stall  output  1  freeze PC, F/D/E/M registers, insert bubble into W.
- ext_req  input  1  external access request, level.
- ext_we, ext_byte  input  1 each  external write enable / byte mode.
- ext_addr, ext_wd  input  32 each  external address / write data.
- ext_gnt  output  1  DM driven by external request this cycle.
- ext_done  output  1  one-cycle completion pulse.
- ext_rd  output  32  registered read data, valid while ext_done=1.
- dm_we, dm_byte  output  1 each  to DM.
- dm_addr, dm_wd  output  32 each  to DM.
- dm_rd  input  32  DM combinational read data.

## Operation
- States: IDLE, DONE. IDLE -> DONE when ext_gnt=1; DONE -> IDLE unconditionally next cycle.
- Grant (combinational, IDLE only): ext wins if ext_req=1 and (cpu_req=0 or wait_cnt >= STARVE_MAX); otherwise CPU owns the port. In DONE, ext never wins (requester must drop ext_req while it sees ext_done).
- ext_gnt = ext wins. cpu_stall = ext wins and cpu_req=1.
- DM mux: ext wins -> ext_we/ext_byte/ext_addr/ext_wd; else cpu_we&cpu_req / cpu_byte / cpu_addr / cpu_wd. dm_we never asserted for a non-granted requester.
- cpu_rd = dm_rd when CPU owns port, else 0.
- wait_cnt (4 bits): cleared on ext grant or ext_req=0; incremented when ext_req=1, state IDLE, CPU wins with cpu_req=1; saturates at 15.
- ext_rd: loaded from dm_rd on the ext_gnt edge; held otherwise.
- ext_done = (state == DONE).
- Addresses/data pass unmodified; no width conversion.

## Timing
- Reset (reset=0 at an edge): state IDLE, wait_cnt 0, ext_rd 0, ext_done 0. While reset=0: ext_gnt 0, cpu_stall 0, dm_we 0, cpu_rd 0.
- CPU access: zero added latency; same-cycle DM access, write at end of cycle.
- External access: ext_gnt in cycle N (write commits at edge closing N), ext_done=1 and ext_rd valid in cycle N+1 only.
- Stalled CPU holds all cpu_* inputs stable; it is served in cycle N+1 (ext cannot win in DONE).
- Worst-case external wait under continuous cpu_req: STARVE_MAX lost cycles, grant in the next.
- Back-to-back external accesses: minimum 2 cycles apart (grant, done).
- Reset asserted in DONE: ext_done drops next cycle; an in-flight external write already committed is not undone.

## Test plan
- Reset: hold reset=0 3 cycles with all requests high -> dm_we=0, ext_gnt=0, cpu_stall=0, ext_done=0; release -> ext_rd=0.
- CPU only: cpu_req=1, cpu_we=1, addr 0x10, wd 0x12345678; then load 0x10 -> cpu_rd=0x12345678, cpu_stall never 1.
- External only: ext_req=1 write 0x20=0xCAFEBABE, then read 0x20 -> ext_gnt one cycle each, ext_done next cycle, ext_rd=0xCAFEBABE.
- Contention, STARVE_MAX=4: cpu_req held 1 every cycle, ext_req rises cycle 0 -> CPU wins cycles 0-3, ext_gnt and cpu_stall=1 in cycle 4, ext_done cycle 5 with CPU served, wait_cnt 0.
- Collision write: CPU and ext both write 0x30 (0x1111/0x2222) with ext forced -> DM holds ext value after cycle 4, CPU value after cycle 5; final read 0x00001111.
- Reset mid-transaction: reset=0 in DONE cycle -> ext_done 0 next cycle, state IDLE, wait_cnt 0.
